// File: rtl/seg_display_scheduler.sv
// Scan scheduler for a multiplexed seven-segment display with one shared BCD decoder.
// Latency: busy_o high VAL_W+1 cycles per load; an_o/seg_o lag bcd_o by one cycle.
// Backpressure: none; load_i is ignored while busy_o=1, and the scan never stalls.
//
// Ports: clk/rst (sync, active-high); value_i/load_i start a binary-to-BCD conversion;
// busy_o flags a conversion; bcd_o feeds the external decoder, seg_i is its active-low
// output; seg_o/an_o are the registered active-low segment and anode pins.
// Option: define BLANK_LEADING_ZEROS_EN to drive 4'hF (blank) on digits above the
// most significant nonzero digit; digit 0 is never blanked.
module seg_display_scheduler #(
    parameter int N_DIG    = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value_i,
    input  logic             load_i,
    output logic             busy_o,
    output logic [3:0]       bcd_o,
    input  logic [6:0]       seg_i,
    output logic [6:0]       seg_o,
    output logic [N_DIG-1:0] an_o
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int SCR_W = BCD_W + VAL_W;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(10 ** N_DIG - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         digit;
`ifdef BLANK_LEADING_ZEROS_EN
    logic [N_DIG-1:0]   blank_q, blank_d;
`endif

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [SCR_W-1:0] dd_step(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] t;
        t = s;
        for (int i = 0; i < N_DIG; i++) begin
            if (t[VAL_W + 4*i +: 4] >= 4'd5)
                t[VAL_W + 4*i +: 4] = t[VAL_W + 4*i +: 4] + 4'd3;
        end
        return {t[SCR_W-2:0], 1'b0};
    endfunction

`ifdef BLANK_LEADING_ZEROS_EN
    // Bit i set when digit i and every digit above it are zero; digit 0 always lit.
    function automatic logic [N_DIG-1:0] blank_mask(input logic [BCD_W-1:0] b);
        logic [N_DIG-1:0] m;
        logic             seen_nz;
        m       = '0;
        seen_nz = 1'b0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            if (b[4*i +: 4] != 4'd0)
                seen_nz = 1'b1;
            m[i] = ~seen_nz;
        end
        return m;
    endfunction
`endif

    // Conversion FSM next state
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        disp_d    = disp_q;
`ifdef BLANK_LEADING_ZEROS_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    scratch_d = {{BCD_W{1'b0}}, (value_i > MAX_VAL) ? MAX_VAL : value_i};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                scratch_d = dd_step(scratch_q);
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1))
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // Display only changes here, so the scan never shows a half-converted value.
                disp_d  = scratch_q[SCR_W-1 -: BCD_W];
`ifdef BLANK_LEADING_ZEROS_EN
                blank_d = blank_mask(scratch_q[SCR_W-1 -: BCD_W]);
`endif
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Free-running scan: prescaler and digit index, independent of the FSM
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + 1'b1;
        end
        an_d  = ~(N_DIG'(1) << idx_q);
        seg_d = seg_i;
    end

    // Select the current digit's nibble from the display register
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_q == IDX_W'(i))
                digit = disp_q[4*i +: 4];
        end
`ifdef BLANK_LEADING_ZEROS_EN
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_q == IDX_W'(i) && blank_q[i])
                digit = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            scratch_q <= '0;
            disp_q    <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= 7'b1111111;
`ifdef BLANK_LEADING_ZEROS_EN
            // Display resets to 0, which shows as a lone "0".
            blank_q   <= {{(N_DIG-1){1'b1}}, 1'b0};
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            disp_q    <= disp_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
`ifdef BLANK_LEADING_ZEROS_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign bcd_o  = digit;
    assign an_o   = an_q;
    assign seg_o  = seg_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler with a board-level decoder model on seg_i/bcd_o.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_seg_display_scheduler;

    localparam int N  = 4;
    localparam int VW = 14;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_i = 1'b0;
    logic [VW-1:0] value_i = '0;
    logic          busy_o;
    logic [3:0]    bcd_o;
    logic [6:0]    seg_i;
    logic [6:0]    seg_o;
    logic [N-1:0]  an_o;

    seg_display_scheduler #(.N_DIG(N), .VAL_W(VW), .SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst     (rst),
        .value_i (value_i),
        .load_i  (load_i),
        .busy_o  (busy_o),
        .bcd_o   (bcd_o),
        .seg_i   (seg_i),
        .seg_o   (seg_o),
        .an_o    (an_o)
    );

    always #5 clk = ~clk;

    // Board decoder: active-low {g,f,e,d,c,b,a}; codes above 9 are dark
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign seg_i = seg7(bcd_o);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (decimal arithmetic on integers) ----------------
    int           m_disp  = 0;
    int           m_pend  = 0;
    int           m_busy  = 0;   // busy cycles remaining
    int           m_tick  = 0;   // clock edges since reset release
    bit           m_valid = 1'b0;
    logic [N-1:0] m_an    = '1;
    logic [6:0]   m_seg   = '1;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [3:0] m_digit(input int v, input int i);
`ifdef BLANK_LEADING_ZEROS_EN
        if (i > 0 && v < pow10(i)) return 4'hF;
`endif
        return 4'((v / pow10(i)) % 10);
    endfunction

    function automatic int m_idx(input int t);
        return (t / SD) % N;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_disp  = 0;
            m_busy  = 0;
            m_tick  = 0;
            m_an    = '1;
            m_seg   = '1;
            m_valid = 1'b1;
        end else begin
            m_an  = ~(N'(1) << m_idx(m_tick));
            m_seg = seg7(m_digit(m_disp, m_idx(m_tick)));
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end else if (load_i) begin
                m_pend = (int'(value_i) > 9999) ? 9999 : int'(value_i);
                m_busy = VW + 1;
            end
            m_tick++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 32'(busy_o), 32'(m_busy > 0));
            check("an",   32'(an_o),   32'(m_an));
            check("seg",  32'(seg_o),  32'(m_seg));
            check("bcd",  32'(bcd_o),  32'(m_digit(m_disp, m_idx(m_tick))));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_load(input logic [VW-1:0] v);
        @(posedge clk); #1;
        value_i = v;
        load_i  = 1'b1;
        @(posedge clk); #1;
        load_i  = 1'b0;
        value_i = VW'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy_o; k++) @(posedge clk);
        #1;
        check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    // Watch one full scan and compare each lit digit with fixed patterns
    task automatic show_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        for (int k = 0; k < N * SD + 2; k++) begin
            @(negedge clk);
            case (an_o)
                4'b1110: check({tag, "_d0"}, 32'(seg_o), 32'(e0));
                4'b1101: check({tag, "_d1"}, 32'(seg_o), 32'(e1));
                4'b1011: check({tag, "_d2"}, 32'(seg_o), 32'(e2));
                4'b0111: check({tag, "_d3"}, 32'(seg_o), 32'(e3));
                default: check({tag, "_an_onehot"}, 32'(an_o), 32'hE);
            endcase
        end
    endtask

    initial begin
        int blen;
        bit done;

        // Reset held 3 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an",   32'(an_o),   32'hF);
        check("rst_seg",  32'(seg_o),  32'h7F);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("first_an",  32'(an_o),  32'hE);
        check("first_seg", 32'(seg_o), 32'(7'b1000000));

        // Load 1234 and measure busy length
        do_load(14'd1234);
        blen = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (busy_o) blen++;
            else done = 1'b1;
        end
        check("busy_len", 32'(blen), 32'd15);
        show_digits("v1234", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        // Clamp
        do_load(14'd12000);
        wait_idle();
        show_digits("v9999", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

        // Second load while busy is dropped
        do_load(14'd1234);
        repeat (3) @(posedge clk);
        do_load(14'd5678);
        wait_idle();
        show_digits("ignore", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        // Reset at busy cycle 7 of a 4321 conversion
        do_load(14'd4321);
        repeat (6) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_bcd",  32'(bcd_o),  32'd0);
        @(posedge clk); #1;
        check("mid_rst_an", 32'(an_o), 32'hE);

        // Small values exercise leading zeros
        do_load(14'd7);
        wait_idle();
`ifdef BLANK_LEADING_ZEROS_EN
        show_digits("v7", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111);
`else
        show_digits("v7", 7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif
        do_load(14'd0);
        wait_idle();
`ifdef BLANK_LEADING_ZEROS_EN
        show_digits("v0", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);
`else
        show_digits("v0", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif

        // Randomized loads, mid-conversion loads and occasional resets
        for (int it = 0; it < 250; it++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
            if ($urandom_range(0, 24) == 0) begin
                rst    = 1'b1;
                load_i = $urandom_range(0, 1) == 1;
                @(posedge clk); #1;
                rst    = 1'b0;
                load_i = 1'b0;
            end else begin
                case ($urandom_range(0, 3))
                    0:       do_load(VW'($urandom_range(0, 9)));
                    1:       do_load(VW'($urandom_range(10000, 16383)));
                    default: do_load(VW'($urandom_range(0, 9999)));
                endcase
            end
        end
        wait_idle();
        repeat (N * SD) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
